mem_param: RTL and testbench

MEM_PARAM -- requirements
Module: mem_param

---
 rtl/mem_param.sv | 137 +++++++++++++
 tb/tb_mem_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_param.sv
`default_nettype none
// ============================================================================
// Module   : mem_param
// Brief    : DEPTH x DW single-port synchronous RAM with a clear engine.
//            Every reset (and every clr pulse) sweeps CLR_VAL into all words.
//            While the sweep runs, busy is high and wr/rd are dropped.
//            Optional macro MEM_WR_FWD_EN makes a same-cycle wr+rd return
//            the written data (write-first); by default the read returns the
//            old contents (read-first).
// Revision : 1.0 - initial release
// ============================================================================
module mem_param #(
    parameter int unsigned     DW      = 8,
    parameter int unsigned     AW      = 10,
    parameter logic [DW-1:0]   CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr,
    input  logic          rd,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] d_o,
    output logic          d_o_vld,
    output logic          busy
);

    localparam int unsigned c_DEPTH = 2 ** AW;
    // Terminal count held in AW+1 bits so the compare cannot alias on wrap.
    localparam logic [AW:0] c_LAST  = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] c_ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] d_o_q, d_o_d;
    logic          d_o_vld_q, d_o_vld_d;

    logic [DW-1:0] mem_q [c_DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rd_data;
    logic          host_ok;

    // Next-state and sweep counter: clr always (re)starts the sweep at word 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (clr) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == c_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Single write port: the sweep owns it in CLEAR, the host owns it in IDLE.
    always_comb begin
        host_ok   = (state_q == S_IDLE);
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = d_i;
        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[AW-1:0];
            mem_wdata = CLR_VAL;
        end else if (wr) begin
            mem_we    = 1'b1;
        end
    end

    // Read path and registered output; d_o holds when no read is accepted.
    always_comb begin
        rd_data = mem_q[addr];
`ifdef MEM_WR_FWD_EN
        // addr is shared, so wr+rd always target the same word.
        if (wr) begin
            rd_data = d_i;
        end
`else
        rd_data = mem_q[addr];
`endif
        d_o_vld_d = host_ok && rd;
        d_o_d     = d_o_vld_d ? rd_data : d_o_q;
    end

    // Control and output registers; reset forces a fresh sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            cnt_q     <= '0;
            d_o_q     <= '0;
            d_o_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_o_q     <= d_o_d;
            d_o_vld_q <= d_o_vld_d;
        end
    end

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign d_o     = d_o_q;
    assign d_o_vld = d_o_vld_q;
    assign busy    = (state_q == S_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_mem_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_param
// Brief    : Directed bench for mem_param (DW=8/AW=4 and DW=32/AW=2).
//            Reads push expected data into queues; monitors pop on d_o_vld.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_param;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic        clr = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [3:0]  addr = '0;
    logic [7:0]  d_i  = '0;
    logic [7:0]  d_o;
    logic        d_o_vld, busy;

    logic        clr2 = 1'b0, wr2 = 1'b0, rd2 = 1'b0;
    logic [1:0]  addr2 = '0;
    logic [31:0] d_i2  = '0;
    logic [31:0] d_o2;
    logic        d_o_vld2, busy2;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q  [$];
    logic [31:0] exp2_q [$];

    always #5 clk = ~clk;

    mem_param #(.DW(8), .AW(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .wr      (wr),
        .rd      (rd),
        .addr    (addr),
        .d_i     (d_i),
        .d_o     (d_o),
        .d_o_vld (d_o_vld),
        .busy    (busy)
    );

    mem_param #(.DW(32), .AW(2)) u_dut32 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr2),
        .wr      (wr2),
        .rd      (rd2),
        .addr    (addr2),
        .d_i     (d_i2),
        .d_o     (d_o2),
        .d_o_vld (d_o_vld2),
        .busy    (busy2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (d_o_vld !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("spurious_d_o_vld", 64'(d_o_vld), 64'd0);
            end else begin
                check("read_data", 64'(d_o), 64'(exp_q.pop_front()));
            end
        end
    end

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (d_o_vld2 !== 1'b0) begin
            if (exp2_q.size() == 0) begin
                check("spurious_d_o_vld32", 64'(d_o_vld2), 64'd0);
            end else begin
                check("read_data32", 64'(d_o2), 64'(exp2_q.pop_front()));
            end
        end
    end

    // Counts rising edges seen with busy high; optional clr / dropped write.
    task automatic sweep(input int clr_at, input int wr_at, output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            clr = (n == clr_at);
            wr  = (n == wr_at);
            if (n == wr_at) begin
                addr = 4'd2;
                d_i  = 8'h7E;
            end
            @(negedge clk);
        end
        clr = 1'b0;
        wr  = 1'b0;
    endtask

    task automatic rd8(input logic [3:0] a, input logic [7:0] e);
        rd   = 1'b1;
        addr = a;
        exp_q.push_back(e);
        @(negedge clk);
        rd   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        // Asynchronous reset with no clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("reset_busy",    64'(busy),    64'd1);
        check("reset_d_o",     64'(d_o),     64'd0);
        check("reset_d_o_vld", 64'(d_o_vld), 64'd0);
        check("reset_busy32",  64'(busy2),   64'd1);
        @(negedge clk);
        @(negedge clk);

        // Power-up sweep with rd held high; reads are dropped while busy.
        rd    = 1'b1;
        addr  = 4'd0;
        rst_n = 1'b1;
        sweep(0, 0, n);
        check("sweep_len_reset", 64'(n), 64'd16);
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            exp_q.push_back(8'h00);
            @(negedge clk);
        end
        rd = 1'b0;
        @(negedge clk);

        // Write then read, then hold.
        wr = 1'b1; addr = 4'd5; d_i = 8'hA5;
        @(negedge clk);
        wr = 1'b0;
        rd8(4'd5, 8'hA5);
        @(negedge clk);
        check("d_o_vld_idle", 64'(d_o_vld), 64'd0);
        check("d_o_hold",     64'(d_o),     64'hA5);

        // Same-cycle write and read to one address.
        wr = 1'b1; addr = 4'd3; d_i = 8'h11;
        @(negedge clk);
        rd = 1'b1; d_i = 8'h22;
`ifdef MEM_WR_FWD_EN
        exp_q.push_back(8'h22);
`else
        exp_q.push_back(8'h11);
`endif
        @(negedge clk);
        wr = 1'b0;
        exp_q.push_back(8'h22);
        @(negedge clk);

        // clr in IDLE: the read in the same cycle is still honoured.
        clr = 1'b1;
        exp_q.push_back(8'h22);
        @(negedge clk);
        clr = 1'b0; rd = 1'b0;
        sweep(0, 0, n);
        check("sweep_len_clr", 64'(n), 64'd16);

        // clr during CLEAR restarts the sweep from word 0.
        clr = 1'b1;
        @(negedge clk);
        sweep(6, 0, n);
        check("sweep_len_restart", 64'(n), 64'd22);
        rd8(4'd3, 8'h00);

        // Fill with FF, clear, and attempt a write mid-sweep.
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; addr = 4'(i); d_i = 8'hFF;
            @(negedge clk);
        end
        wr = 1'b0;
        rd8(4'd9, 8'hFF);
        clr = 1'b1;
        @(negedge clk);
        sweep(0, 8, n);
        check("sweep_len_drop_wr", 64'(n), 64'd16);
        rd8(4'd2,  8'h00);
        rd8(4'd15, 8'h00);
        rd8(4'd0,  8'h00);

        // Reset in mid-sweep while d_o holds 5A.
        wr = 1'b1; addr = 4'd7; d_i = 8'h5A;
        @(negedge clk);
        wr  = 1'b0;
        clr = 1'b1; rd = 1'b1;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        clr = 1'b0; rd = 1'b0;
        repeat (10) @(negedge clk);
        check("d_o_before_rst", 64'(d_o), 64'h5A);
        #2 rst_n = 1'b0;
        #1;
        check("midsweep_rst_d_o",  64'(d_o),     64'd0);
        check("midsweep_rst_vld",  64'(d_o_vld), 64'd0);
        check("midsweep_rst_busy", 64'(busy),    64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(0, 0, n);
        check("sweep_len_after_rst", 64'(n), 64'd16);
        rd8(4'd7, 8'h00);

        // Wide / shallow instance.
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        m = 0;
        while (busy2 === 1'b1 && m < 50) begin
            m++;
            @(negedge clk);
        end
        check("sweep_len32", 64'(m), 64'd4);
        wr2 = 1'b1; addr2 = 2'd3; d_i2 = 32'hDEADBEEF;
        @(negedge clk);
        wr2 = 1'b0; rd2 = 1'b1;
        exp2_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        addr2 = 2'd0;
        exp2_q.push_back(32'h0);
        @(negedge clk);
        rd2 = 1'b0;
        @(negedge clk);
        @(negedge clk);

        check("pending_reads",   64'(exp_q.size()),  64'd0);
        check("pending_reads32", 64'(exp2_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
